// File: rtl/instruction_prefetch_buffer_if.sv
// Fetch-side bus bundle: instruction-memory handshake, redirect/hold control
// and the head-of-buffer instruction presented to decode.
interface instruction_prefetch_buffer_if;
   logic        memory_request;
   logic [31:0] memory_address;
   logic        memory_ready;
   logic        memory_response_valid;
   logic [31:0] memory_response_data;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        hold;
   logic        instruction_valid;
   logic [31:0] instruction;
   logic [31:0] program_counter;
   logic [31:0] program_counter_plus4;

   modport master (
      output memory_request, memory_address,
      input  memory_ready, memory_response_valid, memory_response_data,
      input  redirect, redirect_target, hold,
      output instruction_valid, instruction, program_counter, program_counter_plus4
   );

   modport slave (
      input  memory_request, memory_address,
      output memory_ready, memory_response_valid, memory_response_data,
      output redirect, redirect_target, hold,
      input  instruction_valid, instruction, program_counter, program_counter_plus4
   );
endinterface

// File: rtl/instruction_prefetch_buffer.sv
// In-order instruction prefetcher: credit-limited memory reads, a small
// {pc, word} FIFO toward decode, and redirect flush with in-flight discard.
module instruction_prefetch_buffer #(
   parameter int unsigned DEPTH        = 4,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input logic                           system_clock,
   input logic                           reset,
   instruction_prefetch_buffer_if.master bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } entry_t;

   entry_t           entries [DEPTH];
   logic [31:0]      fetch_pc, fetch_pc_next;
   logic [31:0]      response_pc, response_pc_next;
   logic [CNT_W-1:0] in_flight, in_flight_next;
   logic [CNT_W-1:0] discard, discard_next;
   logic [CNT_W-1:0] occupancy, occupancy_next;
   logic [PTR_W-1:0] head, head_next;
   logic [PTR_W-1:0] tail, tail_next;
   logic             credit_ok, accept, response_ok, push, pop;
   logic [31:0]      target_aligned;

   // Buffered entries plus outstanding reads never exceed DEPTH, so a push always has room.
   assign target_aligned     = bus.redirect_target & 32'hFFFF_FFFC;
   assign credit_ok          = (SUM_W'(occupancy) + SUM_W'(in_flight)) < SUM_W'(DEPTH);
   assign bus.memory_request = ~reset & ~bus.redirect & credit_ok;
   assign accept             = bus.memory_request & bus.memory_ready;
   assign response_ok        = bus.memory_response_valid & (in_flight != '0);
   assign push               = response_ok & ~bus.redirect & (discard == '0);
   assign pop                = (occupancy != '0) & ~bus.hold & ~bus.redirect;

   always_comb begin
      fetch_pc_next    = fetch_pc;
      response_pc_next = response_pc;
      in_flight_next   = in_flight + CNT_W'(accept) - CNT_W'(response_ok);
      discard_next     = discard;
      occupancy_next   = occupancy;
      head_next        = head;
      tail_next        = tail;
      if (bus.redirect) begin
         // Everything outstanding now, minus the response dropped this cycle, is stale.
         fetch_pc_next    = target_aligned;
         response_pc_next = target_aligned;
         discard_next     = in_flight - CNT_W'(response_ok);
         occupancy_next   = '0;
         head_next        = '0;
         tail_next        = '0;
      end else begin
         if (accept) fetch_pc_next = fetch_pc + 32'd4;
         if (response_ok && (discard != '0)) discard_next = discard - CNT_W'(1);
         if (push) begin
            response_pc_next = response_pc + 32'd4;
            tail_next        = tail + PTR_W'(1);
         end
         if (pop) head_next = head + PTR_W'(1);
         occupancy_next = occupancy + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge system_clock) begin
      if (reset) begin
         fetch_pc    <= RESET_VECTOR;
         response_pc <= RESET_VECTOR;
         in_flight   <= '0;
         discard     <= '0;
         occupancy   <= '0;
         head        <= '0;
         tail        <= '0;
      end else begin
         fetch_pc    <= fetch_pc_next;
         response_pc <= response_pc_next;
         in_flight   <= in_flight_next;
         discard     <= discard_next;
         occupancy   <= occupancy_next;
         head        <= head_next;
         tail        <= tail_next;
      end
   end

   // Storage needs no reset: outputs are masked whenever the FIFO is empty.
   always_ff @(posedge system_clock) begin
      if (push) entries[tail] <= '{pc: response_pc, word: bus.memory_response_data};
   end

   assign bus.memory_address        = fetch_pc;
   assign bus.instruction_valid     = (occupancy != '0);
   assign bus.instruction           = bus.instruction_valid ? entries[head].word : 32'h0;
   assign bus.program_counter       = bus.instruction_valid ? entries[head].pc : 32'h0;
   assign bus.program_counter_plus4 = bus.instruction_valid ? entries[head].pc + 32'd4 : 32'h0;
endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Directed bench for instruction_prefetch_buffer with a fixed-latency in-order
// memory model returning (address ^ key) as the instruction word.
module tb_instruction_prefetch_buffer;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   passes = 0;

   int          lat;
   logic [31:0] key;
   int          accept_count;
   int          mem_cyc;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;
   req_t q[$];

   instruction_prefetch_buffer_if bus();

   instruction_prefetch_buffer #(.DEPTH(4), .RESET_VECTOR(32'h0000_0000)) dut (
      .system_clock(clk),
      .reset       (reset),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // Memory: responses driven at negedge, accepts sampled just before posedge.
   initial begin
      mem_cyc = 0;
      accept_count = 0;
      bus.memory_response_valid = 1'b0;
      bus.memory_response_data  = 32'h0;
      forever begin
         @(negedge clk);
         if (q.size() > 0 && q[0].due <= mem_cyc) begin
            bus.memory_response_valid = 1'b1;
            bus.memory_response_data  = q[0].addr ^ key;
            void'(q.pop_front());
         end else begin
            bus.memory_response_valid = 1'b0;
            bus.memory_response_data  = 32'h0;
         end
         #4;
         if (reset) q.delete();
         else if (bus.memory_request && bus.memory_ready) begin
            q.push_back('{addr: bus.memory_address, due: mem_cyc + lat});
            accept_count++;
         end
         mem_cyc++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic reset_dut(input int l, input logic [31:0] k);
      @(negedge clk);
      reset = 1'b1;
      bus.redirect = 1'b0;
      bus.hold = 1'b0;
      bus.memory_ready = 1'b1;
      lat = l;
      key = k;
      repeat (3) @(negedge clk);
      accept_count = 0;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++; if (bus.memory_request !== 1'b0) $display("FAIL reset_req got %b want 0", bus.memory_request); else passes++;
      checks++; if (bus.memory_address !== 32'h0) $display("FAIL reset_addr got %h want 0", bus.memory_address); else passes++;
      checks++; if (bus.instruction_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.instruction_valid); else passes++;
      checks++; if (bus.instruction !== 32'h0) $display("FAIL reset_instr got %h want 0", bus.instruction); else passes++;
      checks++; if (bus.program_counter !== 32'h0) $display("FAIL reset_pc got %h want 0", bus.program_counter); else passes++;
      checks++; if (bus.program_counter_plus4 !== 32'h0) $display("FAIL reset_pc4 got %h want 0", bus.program_counter_plus4); else passes++;
   endtask

   task automatic test_stream();
      logic [31:0] e;
      reset_dut(1, 32'h0);
      #1;
      checks++; if (bus.memory_request !== 1'b1) $display("FAIL stream_first_req got %b want 1", bus.memory_request); else passes++;
      @(negedge clk); #1;
      checks++; if (bus.instruction_valid !== 1'b0) $display("FAIL stream_early_valid got %b want 0", bus.instruction_valid); else passes++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         e = 32'(4 * i);
         checks++; if (bus.instruction_valid !== 1'b1 || bus.program_counter !== e)
            $display("FAIL stream_pc[%0d] got %b/%h want 1/%h", i, bus.instruction_valid, bus.program_counter, e); else passes++;
         checks++; if (bus.instruction !== e || bus.program_counter_plus4 !== e + 32'd4)
            $display("FAIL stream_data[%0d] got %h/%h want %h/%h", i, bus.instruction, bus.program_counter_plus4, e, e + 32'd4); else passes++;
      end
   endtask

   task automatic test_hold();
      logic [31:0] e;
      reset_dut(1, 32'hA000_0000);
      bus.hold = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      checks++; if (accept_count !== 4) $display("FAIL hold_accepts got %0d want 4", accept_count); else passes++;
      checks++; if (bus.memory_request !== 1'b0) $display("FAIL hold_req got %b want 0", bus.memory_request); else passes++;
      checks++; if (bus.instruction_valid !== 1'b1 || bus.program_counter !== 32'h0 || bus.instruction !== 32'hA000_0000)
         $display("FAIL hold_head got %b/%h/%h want 1/0/a0000000", bus.instruction_valid, bus.program_counter, bus.instruction); else passes++;
      bus.hold = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk); #1;
         e = 32'(4 * i);
         checks++; if (bus.program_counter !== e || bus.instruction !== (e ^ key))
            $display("FAIL hold_release[%0d] got %h/%h want %h/%h", i, bus.program_counter, bus.instruction, e, e ^ key); else passes++;
      end
   endtask

   task automatic test_redirect_inflight();
      reset_dut(4, 32'h5500_0000);
      repeat (3) @(negedge clk);
      bus.memory_ready = 1'b0;
      bus.redirect = 1'b1;
      bus.redirect_target = 32'h0000_1003;
      #1;
      checks++; if (bus.memory_request !== 1'b0) $display("FAIL rinf_req_in_redirect got %b want 0", bus.memory_request); else passes++;
      @(negedge clk);
      bus.redirect = 1'b0;
      bus.memory_ready = 1'b1;
      #1;
      checks++; if (bus.memory_request !== 1'b1 || bus.memory_address !== 32'h0000_1000)
         $display("FAIL rinf_new_addr got %b/%h want 1/00001000", bus.memory_request, bus.memory_address); else passes++;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin @(negedge clk); #1; end
         checks++; if (bus.instruction_valid !== 1'b0) $display("FAIL rinf_stale_valid[%0d] got %b want 0", i, bus.instruction_valid); else passes++;
      end
      @(negedge clk); #1;
      checks++; if (bus.instruction_valid !== 1'b1 || bus.program_counter !== 32'h1000 || bus.instruction !== (32'h1000 ^ key))
         $display("FAIL rinf_first got %b/%h/%h want 1/1000/%h", bus.instruction_valid, bus.program_counter, bus.instruction, 32'h1000 ^ key); else passes++;
      @(negedge clk); #1;
      checks++; if (bus.program_counter !== 32'h1004) $display("FAIL rinf_second got %h want 1004", bus.program_counter); else passes++;
   endtask

   task automatic test_redirect_collision();
      reset_dut(1, 32'h00C0_0000);
      repeat (4) @(negedge clk);
      bus.redirect = 1'b1;
      bus.redirect_target = 32'h0000_0040;
      #1;
      checks++; if (bus.instruction_valid !== 1'b1 || bus.program_counter !== 32'h8 || bus.memory_response_valid !== 1'b1)
         $display("FAIL coll_setup got %b/%h/%b want 1/8/1", bus.instruction_valid, bus.program_counter, bus.memory_response_valid); else passes++;
      @(negedge clk);
      bus.redirect = 1'b0;
      #1;
      checks++; if (bus.instruction_valid !== 1'b0 || bus.memory_address !== 32'h40)
         $display("FAIL coll_flush got %b/%h want 0/40", bus.instruction_valid, bus.memory_address); else passes++;
      @(negedge clk); #1;
      checks++; if (bus.instruction_valid !== 1'b0) $display("FAIL coll_gap got %b want 0", bus.instruction_valid); else passes++;
      @(negedge clk); #1;
      checks++; if (bus.instruction_valid !== 1'b1 || bus.program_counter !== 32'h40 || bus.instruction !== (32'h40 ^ key))
         $display("FAIL coll_first got %b/%h/%h want 1/40/%h", bus.instruction_valid, bus.program_counter, bus.instruction, 32'h40 ^ key); else passes++;
   endtask

   task automatic test_back_to_back();
      reset_dut(1, 32'h0B00_0000);
      repeat (3) @(negedge clk);
      bus.hold = 1'b1;
      bus.redirect = 1'b1;
      bus.redirect_target = 32'h0000_0200;
      @(negedge clk);
      bus.redirect_target = 32'h0000_0300;
      #1;
      checks++; if (bus.instruction_valid !== 1'b0 || bus.memory_request !== 1'b0)
         $display("FAIL b2b_flush_under_hold got %b/%b want 0/0", bus.instruction_valid, bus.memory_request); else passes++;
      @(negedge clk);
      bus.redirect = 1'b0;
      bus.hold = 1'b0;
      #1;
      checks++; if (bus.instruction_valid !== 1'b0 || bus.memory_address !== 32'h300)
         $display("FAIL b2b_addr got %b/%h want 0/300", bus.instruction_valid, bus.memory_address); else passes++;
      @(negedge clk); #1;
      checks++; if (bus.instruction_valid !== 1'b0) $display("FAIL b2b_gap got %b want 0", bus.instruction_valid); else passes++;
      @(negedge clk); #1;
      checks++; if (bus.instruction_valid !== 1'b1 || bus.program_counter !== 32'h300)
         $display("FAIL b2b_first got %b/%h want 1/300", bus.instruction_valid, bus.program_counter); else passes++;
      @(negedge clk); #1;
      checks++; if (bus.program_counter !== 32'h304) $display("FAIL b2b_second got %h want 304", bus.program_counter); else passes++;
   endtask

   task automatic test_wrap();
      reset_dut(1, 32'h0D00_0000);
      repeat (3) @(negedge clk);
      bus.redirect = 1'b1;
      bus.redirect_target = 32'hFFFF_FFFB;
      @(negedge clk);
      bus.redirect = 1'b0;
      #1;
      checks++; if (bus.memory_address !== 32'hFFFF_FFF8) $display("FAIL wrap_target got %h want fffffff8", bus.memory_address); else passes++;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (bus.program_counter !== 32'hFFFF_FFF8 || bus.program_counter_plus4 !== 32'hFFFF_FFFC)
         $display("FAIL wrap_pc0 got %h/%h want fffffff8/fffffffc", bus.program_counter, bus.program_counter_plus4); else passes++;
      checks++; if (bus.memory_address !== 32'h0) $display("FAIL wrap_addr got %h want 0", bus.memory_address); else passes++;
      @(negedge clk); #1;
      checks++; if (bus.program_counter !== 32'hFFFF_FFFC || bus.program_counter_plus4 !== 32'h0)
         $display("FAIL wrap_pc1 got %h/%h want fffffffc/0", bus.program_counter, bus.program_counter_plus4); else passes++;
      @(negedge clk); #1;
      checks++; if (bus.program_counter !== 32'h0 || bus.instruction !== key || bus.program_counter_plus4 !== 32'h4)
         $display("FAIL wrap_pc2 got %h/%h/%h want 0/%h/4", bus.program_counter, bus.instruction, bus.program_counter_plus4, key); else passes++;
   endtask

   initial begin
      reset = 1'b1;
      lat = 1;
      key = 32'h0;
      bus.redirect = 1'b0;
      bus.redirect_target = 32'h0;
      bus.hold = 1'b0;
      bus.memory_ready = 1'b0;
      test_reset();
      test_stream();
      test_hold();
      test_redirect_inflight();
      test_redirect_collision();
      test_back_to_back();
      test_wrap();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
